// File: rtl/colour_led_player.sv
// Colour LED sequence player: captures a streamed round of 2-bit colour codes into a
// 16-entry buffer, then lights each colour for HOLD_CYCLES with GAP_CYCLES dark between.
module colour_led_player #(
    parameter logic [15:0] HOLD_CYCLES = 16'd1000,
    parameter logic [15:0] GAP_CYCLES  = 16'd250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] colour_in,
    input  logic       colour_valid,
    input  logic       stream_done,
    input  logic       clear,
    output logic [3:0] led,
    output logic       busy,
    output logic       play_done,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHOW    = 2'd2,
        ST_GAP     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [3:0]  rptr_q, rptr_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  led_q, led_d;
    logic        busy_q, busy_d;
    logic        play_done_q, play_done_d;
    logic        overflow_q, overflow_d;

    logic [1:0]  colour_mem_q [16];
    logic        wr_en_s;
    logic [3:0]  wr_addr_s;
    logic        advance_s;
    logic        last_s;
    logic        intrude_s;
    logic [3:0]  next_idx_s;

    function automatic logic [3:0] onehot4(input logic [1:0] code);
        onehot4 = 4'b0001 << code;
    endfunction

    // Next-state, datapath and output computation for the player.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rptr_d      = rptr_q;
        timer_d     = timer_q;
        led_d       = led_q;
        busy_d      = busy_q;
        play_done_d = 1'b0;
        overflow_d  = overflow_q;
        wr_en_s     = 1'b0;
        wr_addr_s   = count_q[3:0];
        advance_s   = 1'b0;
        intrude_s   = colour_valid | stream_done;
        next_idx_s  = rptr_q + 4'd1;
        last_s      = ({1'b0, rptr_q} == (count_q - 5'd1));

        if (clear) begin
            state_d    = ST_IDLE;
            count_d    = 5'd0;
            rptr_d     = 4'd0;
            timer_d    = 16'd0;
            led_d      = 4'b0000;
            busy_d     = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_d   = 4'b0000;
                    busy_d  = 1'b0;
                    count_d = 5'd0;
                    rptr_d  = 4'd0;
                    timer_d = 16'd0;
                    if (colour_valid) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = 4'd0;
                        count_d   = 5'd1;
                        busy_d    = 1'b1;
                        // Single-colour round: the buffer is not written yet, so bypass it.
                        if (stream_done) begin
                            state_d = ST_SHOW;
                            timer_d = HOLD_CYCLES;
                            led_d   = onehot4(colour_in);
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    busy_d = 1'b1;
                    led_d  = 4'b0000;
                    if (colour_valid) begin
                        if (count_q >= 5'd16) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en_s = 1'b1;
                            count_d = count_q + 5'd1;
                        end
                    end else begin
                        count_d = count_q;
                    end
                    if (stream_done) begin
                        state_d = ST_SHOW;
                        rptr_d  = 4'd0;
                        timer_d = HOLD_CYCLES;
                        led_d   = onehot4(colour_mem_q[4'd0]);
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_SHOW: begin
                    if (intrude_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                    if (timer_q <= 16'd1) begin
                        if (GAP_CYCLES != 16'd0) begin
                            state_d = ST_GAP;
                            timer_d = GAP_CYCLES;
                            led_d   = 4'b0000;
                        end else begin
                            advance_s = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                ST_GAP: begin
                    if (intrude_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                    if (timer_q <= 16'd1) begin
                        advance_s = 1'b1;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = 5'd0;
                    rptr_d  = 4'd0;
                    timer_d = 16'd0;
                    led_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            endcase

            // End of a colour slot: either finish the round or move to the next entry.
            if (advance_s) begin
                if (last_s) begin
                    state_d     = ST_IDLE;
                    count_d     = 5'd0;
                    rptr_d      = 4'd0;
                    timer_d     = 16'd0;
                    led_d       = 4'b0000;
                    busy_d      = 1'b0;
                    play_done_d = 1'b1;
                end else begin
                    state_d = ST_SHOW;
                    rptr_d  = next_idx_s;
                    timer_d = HOLD_CYCLES;
                    led_d   = onehot4(colour_mem_q[next_idx_s]);
                end
            end else begin
                play_done_d = 1'b0;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= 5'd0;
            rptr_q      <= 4'd0;
            timer_q     <= 16'd0;
            led_q       <= 4'b0000;
            busy_q      <= 1'b0;
            play_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rptr_q      <= rptr_d;
            timer_q     <= timer_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            play_done_q <= play_done_d;
            overflow_q  <= overflow_d;
        end
    end

    // Colour buffer; entries are only read below the current count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            colour_mem_q[wr_addr_s] <= colour_in;
        end
    end

    assign led       = led_q;
    assign busy      = busy_q;
    assign play_done = play_done_q;
    assign overflow  = overflow_q;

endmodule
